// File: rtl/multiplier_pkg.sv
`default_nettype none
// ============================================================================
// Module      : multiplier_pkg
// Description : Shared definitions for the shift-and-add multiplier. Holds the
//               default operand/counter widths and the control state encoding
//               used by the lab arithmetic unit (the divider uses the same
//               encoding).
// Revision    : 1.0 - initial release
// ============================================================================
package multiplier_pkg;

  // Default operand width; the product is twice this wide.
  localparam int DEF_N    = 8;
  // ceil(log2(DEF_N)); width of the debug bit counter.
  localparam int DEF_LOGN = 3;

  // Control states: S1 idle/load, S2 compute, S3 done. 2'b11 is unused and
  // falls back to S1.
  typedef enum logic [1:0] {
    S1 = 2'b00,
    S2 = 2'b01,
    S3 = 2'b10
  } state_t;

endpackage : multiplier_pkg
`default_nettype wire

// File: rtl/multiplier_if.sv
`default_nettype none
// ============================================================================
// Module      : multiplier_if
// Description : Operand/handshake bundle for the multiplier.
//               s        start, level-sensitive, held until done is seen
//               la / lb  load multiplicand / multiplier (idle state only)
//               data_a   multiplicand, unsigned, N bits
//               data_b   multiplier, unsigned, N bits
//               p        product register, 2N bits
//               done     high while the result is being presented
//               count    bits processed in the current operation
//               master : drives the operands and the start request
//               slave  : the multiplier itself
// Revision    : 1.0 - initial release
// ============================================================================
interface multiplier_if
  import multiplier_pkg::*;
#(
  parameter int N    = DEF_N,
  parameter int LOGN = DEF_LOGN
);

  logic             s;
  logic             la;
  logic             lb;
  logic [N-1:0]     data_a;
  logic [N-1:0]     data_b;
  logic [2*N-1:0]   p;
  logic             done;
  logic [LOGN-1:0]  count;

  modport master (
    output s, la, lb, data_a, data_b,
    input  p, done, count
  );

  modport slave (
    input  s, la, lb, data_a, data_b,
    output p, done, count
  );

endinterface : multiplier_if
`default_nettype wire

// File: rtl/multiplier_shiftrne.sv
`default_nettype none
// ============================================================================
// Module      : multiplier_shiftrne
// Description : N-bit right shift register with parallel load and enable.
//               Load has priority over shift; w is shifted into the MSB.
//               Ports: clk, rst_n (async, active-low), r (parallel data),
//               l (load), e (shift enable), w (serial in), q (contents).
// Revision    : 1.0 - initial release
// ============================================================================
module multiplier_shiftrne #(
  parameter int N = 8
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  input  wire logic [N-1:0] r,
  input  wire logic         l,
  input  wire logic         e,
  input  wire logic         w,
  output logic      [N-1:0] q
);

  logic [N-1:0] q_q;
  logic [N-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (l) begin
      q_d = r;
    end else if (e) begin
      q_d = {w, q_q[N-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule : multiplier_shiftrne
`default_nettype wire

// File: rtl/multiplier.sv
`default_nettype none
// ============================================================================
// Module      : multiplier
// Description : Sequential shift-and-add unsigned multiplier. One multiplier
//               bit is consumed per clock; the operation ends as soon as the
//               remaining multiplier is zero, so short multipliers finish
//               early.
//               Ports: clk, rst_n (async, active-low), bus (multiplier_if
//               slave: s, la, lb, data_a, data_b in; p, done, count out).
// Revision    : 1.0 - initial release
// ============================================================================
module multiplier
  import multiplier_pkg::*;
#(
  parameter int N    = DEF_N,
  parameter int LOGN = DEF_LOGN
) (
  input  wire logic    clk,
  input  wire logic    rst_n,
  multiplier_if.slave  bus
);

  state_t           state_q;
  state_t           state_d;
  logic [2*N-1:0]   a_q;
  logic [2*N-1:0]   a_d;
  logic [2*N-1:0]   p_q;
  logic [2*N-1:0]   p_d;
  logic [LOGN-1:0]  count_q;
  logic [LOGN-1:0]  count_d;
  logic             done_q;
  logic             done_d;

  logic [N-1:0]     b_val;
  logic             b_load;
  logic             b_shift;
  logic             z;

  // Multiplier operand: shifted right one bit per step so that bit 0 always
  // selects whether the (left-shifting) multiplicand is accumulated.
  multiplier_shiftrne #(
    .N (N)
  ) u_b_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .r     (bus.data_b),
    .l     (b_load),
    .e     (b_shift),
    .w     (1'b0),
    .q     (b_val)
  );

  assign z = (b_val == '0);

  // State table and datapath controls.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    p_d     = p_q;
    count_d = count_q;
    b_load  = 1'b0;
    b_shift = 1'b0;

    case (state_q)
      S1: begin
        // Operands load on the same edge that accepts s, so a combined
        // load+start uses the new values.
        if (bus.la) begin
          a_d = {{N{1'b0}}, bus.data_a};
        end
        b_load = bus.lb;
        if (bus.s) begin
          p_d     = '0;
          count_d = '0;
          state_d = S2;
        end
      end

      S2: begin
        if (!z) begin
          // Accumulate using the multiplicand before this step's shift.
          if (b_val[0]) begin
            p_d = p_q + a_q;
          end
          a_d     = a_q << 1;
          b_shift = 1'b1;
          count_d = count_q + 1'b1;
        end else begin
          state_d = S3;
        end
      end

      S3: begin
        if (!bus.s) begin
          state_d = S1;
        end
      end

      default: begin
        state_d = S1;
      end
    endcase

    // Registered so done tracks the state register exactly.
    done_d = (state_d == S3);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S1;
      a_q     <= '0;
      p_q     <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      p_q     <= p_d;
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  assign bus.p     = p_q;
  assign bus.done  = done_q;
  assign bus.count = count_q;

endmodule : multiplier
`default_nettype wire

// File: tb/tb_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : tb_multiplier
// Description : Self-checking bench for the shift-and-add multiplier. Table
//               vectors, hand-written corner sequences and random operands
//               are compared against a plain-arithmetic reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multiplier;

  localparam int N    = 8;
  localparam int LOGN = 3;

  logic clk;
  logic rst_n;

  multiplier_if #(.N(N), .LOGN(LOGN)) bus ();

  multiplier #(.N(N), .LOGN(LOGN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_compared   = 0;
  int n_mismatched = 0;

  typedef struct {
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic [2*N-1:0] p;
    int             edges;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: number of multiplier bits up to and including the top set bit.
  function automatic int bits_used(input logic [N-1:0] b);
    int k = 0;
    int v = int'(b);
    while (v != 0) begin
      v = v / 2;
      k++;
    end
    return k;
  endfunction

  // Full operation: load+start on one edge, wait for done, check the result,
  // hold s one extra cycle, then drop s and check the return to idle.
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [2*N-1:0] exp_p, input int exp_edges,
                        input string tag);
    int   edges;
    logic seen;
    logic [LOGN-1:0] exp_cnt;
    exp_cnt = LOGN'(exp_edges - 2);
    @(negedge clk);
    bus.data_a = a;
    bus.data_b = b;
    bus.la     = 1'b1;
    bus.lb     = 1'b1;
    bus.s      = 1'b1;
    edges = 0;
    seen  = 1'b0;
    while (!seen && edges < 40) begin
      @(posedge clk);
      #1;
      edges++;
      bus.la = 1'b0;
      bus.lb = 1'b0;
      if (edges == 1) chk({tag, "_p_cleared"}, 32'(bus.p), 32'd0);
      if (bus.done) seen = 1'b1;
    end
    chk({tag, "_latency"}, 32'(edges), 32'(exp_edges));
    chk({tag, "_p"}, 32'(bus.p), 32'(exp_p));
    chk({tag, "_count"}, 32'(bus.count), 32'(exp_cnt));
    @(posedge clk);
    #1;
    chk({tag, "_hold_done"}, 32'(bus.done), 32'd1);
    chk({tag, "_hold_p"}, 32'(bus.p), 32'(exp_p));
    bus.s = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, "_idle_done"}, 32'(bus.done), 32'd0);
    chk({tag, "_idle_p"}, 32'(bus.p), 32'(exp_p));
  endtask

  initial begin
    int   edges;
    logic seen;
    logic [N-1:0] ra;
    logic [N-1:0] rb;

    vecs[0] = '{a: 8'd13,  b: 8'd11,  p: 16'd143,   edges: 6};
    vecs[1] = '{a: 8'd255, b: 8'd255, p: 16'd65025, edges: 10};
    vecs[2] = '{a: 8'd200, b: 8'd0,   p: 16'd0,     edges: 2};
    vecs[3] = '{a: 8'd0,   b: 8'd200, p: 16'd0,     edges: 10};
    vecs[4] = '{a: 8'd1,   b: 8'd1,   p: 16'd1,     edges: 3};
    vecs[5] = '{a: 8'd255, b: 8'd128, p: 16'd32640, edges: 10};

    // Reset with random activity on the inputs.
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.s      = 1'($urandom);
      bus.la     = 1'($urandom);
      bus.lb     = 1'($urandom);
      bus.data_a = N'($urandom);
      bus.data_b = N'($urandom);
      @(negedge clk);
    end
    chk("reset_p", 32'(bus.p), 32'd0);
    chk("reset_done", 32'(bus.done), 32'd0);
    chk("reset_count", 32'(bus.count), 32'd0);
    bus.s  = 1'b0;
    bus.la = 1'b0;
    bus.lb = 1'b0;
    rst_n  = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle_done", 32'(bus.done), 32'd0);
    chk("idle_p", 32'(bus.p), 32'd0);

    // Table vectors.
    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].edges, $sformatf("vec%0d", i));
    end

    // Operand loads and s dropping during compute must not disturb the op.
    @(negedge clk);
    bus.data_a = 8'd13;
    bus.data_b = 8'd11;
    bus.la = 1'b1;
    bus.lb = 1'b1;
    bus.s  = 1'b1;
    @(negedge clk);
    bus.data_a = 8'd7;
    bus.data_b = 8'd7;
    @(negedge clk);
    bus.s = 1'b0;
    edges = 2;
    seen  = bus.done;
    while (!seen && edges < 40) begin
      @(posedge clk);
      #1;
      edges++;
      bus.la = 1'b0;
      bus.lb = 1'b0;
      if (bus.done) seen = 1'b1;
    end
    chk("disturb_latency", 32'(edges), 32'd6);
    chk("disturb_p", 32'(bus.p), 32'd143);
    @(posedge clk);
    #1;
    chk("disturb_idle_done", 32'(bus.done), 32'd0);
    chk("disturb_idle_p", 32'(bus.p), 32'd143);

    // Asynchronous reset in the middle of 200*3.
    @(negedge clk);
    bus.data_a = 8'd200;
    bus.data_b = 8'd3;
    bus.la = 1'b1;
    bus.lb = 1'b1;
    bus.s  = 1'b1;
    @(posedge clk);
    #1;
    bus.la = 1'b0;
    bus.lb = 1'b0;
    @(posedge clk);
    #1;
    chk("midop_partial_p", 32'(bus.p), 32'd200);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midop_reset_p", 32'(bus.p), 32'd0);
    chk("midop_reset_done", 32'(bus.done), 32'd0);
    chk("midop_reset_count", 32'(bus.count), 32'd0);
    bus.s = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_op(8'd200, 8'd3, 16'd600, 4, "restart");

    // Back-to-back: s was low for one cycle at the end of the previous op.
    run_op(8'd9, 8'd9, 16'd81, 6, "b2b");

    // Random operands against the arithmetic reference.
    for (int i = 0; i < 30; i++) begin
      ra = N'($urandom);
      rb = (i % 5 == 0) ? N'($urandom_range(0, 3)) : N'($urandom);
      run_op(ra, rb, (2*N)'(ra) * (2*N)'(rb), bits_used(rb) + 2, $sformatf("rand%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule : tb_multiplier
`default_nettype wire
